fetch_sequencer: RTL
====================

# fetch_sequencer

Sequences instruction fetch for the 8-bit model computer. Reads the four bytes of each instruction (opcode and three operand bytes) from byte-wide program memory over a request/acknowledge handshake, one byte at a time. It then presents the assembled instruction to the decode/operand-select stage and updates the program counter on acceptance: sequential advance, jump to the opcode4 target, or return to the stack-supplied address. It is the single owner of the program counter and of the program-memory port.

## Interface
- `ADDR_W`, 8, width of program counter and memory address
- `DATA_W`, 8, width of each instruction byte
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mem_req`  out  1  program-memory read request
- `mem_addr`  out  ADDR_W  byte address of current request
- `mem_ack`  in  1  memory has `mem_rdata` valid this cycle
- `mem_rdata`  in  DATA_W  read data
- `instr_valid`  out  1  opcode1..opcode4 hold a complete instruction
- `instr_ready`  in  1  decode stage accepts the instruction
- `opcode1`, `opcode2`, `opcode3`, `opcode4`  out  DATA_W each  instruction bytes at pc, pc+1, pc+2, pc+3
- `pc`  out  ADDR_W  address of the instruction being fetched or issued
- `condition`  in  1  branch taken; sampled only on the accept cycle
- `isRet`  in  1  taken branch is a return; sampled with `condition`
- `ret_addr`  in  ADDR_W  return target from stack output
- `halt`  in  1  stop after the accepted instruction; sampled on the accept cycle
- `halted`  out  1  sequencer stopped

## Operation
- States:
  - `FETCH`: 2-bit byte index `idx` 0..3.
  - `ISSUE`
  - `HALT`
- FETCH:
  - `mem_req`=1 and `mem_addr`=(pc+idx) mod 2^ADDR_W.
  - On `mem_ack`=1, `mem_rdata` is written into opcode[idx+1].
  - If idx<3, idx increments. If idx=3, idx is cleared and the state goes to ISSUE.
  - `mem_req` stays high across consecutive bytes. `mem_addr` changes only in the cycle after an ack.
  - `mem_ack` while `mem_req`=0 (ISSUE, HALT) is ignored.
- ISSUE:
  - `instr_valid`=1, `mem_req`=0.
  - opcode1..4 and pc are stable until accept.
  - Accept = `instr_valid` & `instr_ready`.
- On accept, the next pc is chosen by priority:
  - `condition`=1 & `isRet`=1: `ret_addr`.
  - `condition`=1 & `isRet`=0: opcode4.
  - Otherwise: pc+4 mod 2^ADDR_W.
- On accept, the next state is HALT if `halt`=1. Otherwise it is FETCH with idx=0. pc updates in both cases.
- HALT:
  - `halted`=1; `mem_req`=0; `instr_valid`=0.
  - Exit only via `rst`.
- `condition`, `isRet`, `ret_addr` and `halt` are don't-care outside the accept cycle.
- Address arithmetic wraps modulo 2^ADDR_W. Example: pc=0xFE fetches 0xFE, 0xFF, 0x00, 0x01; pc=0xFC sequential next is 0x00.

## Timing
- Reset values (at the edge where `rst`=1):
  - pc=0, idx=0, state=FETCH.
  - opcode1..4=0.
  - `mem_req`=0, `instr_valid`=0, `halted`=0.
- `mem_req` rises in the first cycle after `rst` deasserts. It is registered from state, so it is 0 during any cycle with `rst` high.
- Best-case latency with `mem_ack` in the same cycle as each request:
  - 4 fetch cycles.
  - `instr_valid` in cycle 5.
  - If `instr_ready`=1, the next fetch at the new pc starts in cycle 6.
  - Throughput is 1 instruction per 5 cycles.
- Wait states: each cycle with `mem_req`=1 and `mem_ack`=0 adds one cycle with no state change.
- `instr_valid` is a registered output. It is held until accept and falls the cycle after accept.
- Reset mid-fetch or mid-issue:
  - The partial instruction is discarded.
  - Outputs return to reset values at that edge.
  - A late `mem_ack` after reset, while `mem_req` is high for idx=0, is taken as byte 0 of address 0. Memory must not hold an ack across reset.
- Reset has priority over all inputs in the same cycle.

## Test plan
- **Reset and first fetch.** Pulse `rst`, then release. Memory bytes 0..3 = 0x11, 0x22, 0x33, 0x44, acked same cycle. Required:
  - `mem_addr` 0, 1, 2, 3 in cycles 1–4.
  - `instr_valid` in cycle 5 with opcode1..4 = 11/22/33/44 and pc=0.
  - On accept with `condition`=0, pc=0x04.
- **Wait states and back-pressure.** Ack byte 2 only after 3 idle cycles, and hold `instr_ready`=0 for 4 cycles. Required:
  - `mem_addr` is held at pc+2 through the wait.
  - opcode and pc are stable while valid; no new `mem_req` until accept.
- **Jump.** opcode4=0x80, accept with `condition`=1, `isRet`=0. Required: next `mem_addr` sequence 0x80..0x83 and pc=0x80.
- **Return.** Accept with `condition`=1, `isRet`=1, `ret_addr`=0x3C, opcode4=0x80. Required: pc=0x3C (return has priority over jump).
- **Wrap-around.** Jump to 0xFE. Required:
  - Fetch addresses are FE, FF, 00, 01.
  - On sequential accept, pc=0x02.
- **Halt and mid-fetch reset.**
  - Accept with `halt`=1. Required: `halted`=1, `mem_req` stays 0 for 10 cycles, and acks are ignored.
  - Separately, assert `rst` at idx=2. Required: `mem_req`=0 and pc=0 at that edge; a fresh fetch from 0x00 after release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 4-byte instructions byte by byte from program
// memory, presents them to decode, and steers the program counter.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mem_req, mem_addr          program-memory read request and address
//   mem_ack, mem_rdata         memory acknowledge and read data
//   instr_valid, instr_ready   instruction handshake toward decode
//   opcode1..opcode4           assembled instruction bytes (pc..pc+3)
//   pc                         address of instruction in fetch or issue
//   condition, isRet, ret_addr branch controls, sampled on accept
//   halt                       stop after accepted instruction
//   halted                     sequencer stopped until reset

module fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] opcode1,
  output logic [DATA_W-1:0] opcode2,
  output logic [DATA_W-1:0] opcode3,
  output logic [DATA_W-1:0] opcode4,
  output logic [ADDR_W-1:0] pc,
  input  logic              condition,
  input  logic              isRet,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic              halt,
  output logic              halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [1:0]        idx;
  logic [1:0]        idx_n;
  logic              req_n;
  logic              valid_n;
  logic              halted_n;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] target;
  logic              take;

  // mem_req is only ever high in FETCH, so it alone qualifies the ack;
  // acks seen in ISSUE, HALT or the idle cycle after reset fall away.
  assign take = mem_req & mem_ack;

  assign mem_addr = pc + ADDR_W'(idx);

  // Return beats jump; a non-taken branch advances sequentially.
  always_comb begin
    target = pc + ADDR_W'(4);
    if (condition && isRet) begin
      target = ret_addr;
    end else if (condition) begin
      target = ADDR_W'(opcode4);
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pc_n    = pc;
    req_n   = mem_req;
    unique case (state)
      FETCH: begin
        // First cycle out of reset only arms the request.
        req_n = 1'b1;
        if (take) begin
          if (idx == 2'd3) begin
            idx_n   = 2'd0;
            state_n = ISSUE;
            req_n   = 1'b0;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
      ISSUE: begin
        req_n = 1'b0;
        if (instr_ready) begin
          pc_n    = target;
          idx_n   = 2'd0;
          state_n = halt ? HALT : FETCH;
          req_n   = !halt;
        end
      end
      HALT: begin
        req_n = 1'b0;
      end
      default: begin
        state_n = FETCH;
        idx_n   = 2'd0;
        req_n   = 1'b0;
      end
    endcase
    valid_n  = (state_n == ISSUE);
    halted_n = (state_n == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      idx         <= 2'd0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      pc          <= '0;
      opcode1     <= '0;
      opcode2     <= '0;
      opcode3     <= '0;
      opcode4     <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      mem_req     <= req_n;
      instr_valid <= valid_n;
      halted      <= halted_n;
      pc          <= pc_n;
      if (take) begin
        unique case (idx)
          2'd0: opcode1 <= mem_rdata;
          2'd1: opcode2 <= mem_rdata;
          2'd2: opcode3 <= mem_rdata;
          2'd3: opcode4 <= mem_rdata;
          default: opcode1 <= mem_rdata;
        endcase
      end
    end
  end

endmodule
